// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: shared widths, forwarding encodings, stage record and match helper
// Contents: REG_W, FWD_RF/FWD_WB/FWD_MEM, REG_ZERO, reg_t, stage_t, hit()
package hazard_forward_unit_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef logic [REG_W-1:0] reg_t;
  typedef struct packed {
    reg_t dest;
    logic reg_write;
    logic mem_read;
    logic valid;
  } stage_t;
  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic hit(logic valid, logic reg_write, reg_t dest, reg_t src);
    return valid && reg_write && dest != REG_ZERO && dest == src;
  endfunction
endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID/EX hazard inputs and forwarding/stall outputs of the hazard unit
// master: pipeline side, drives id_*/ex_* and reads selects/enables; slave: the hazard unit
interface hazard_forward_unit_if import hazard_forward_unit_pkg::*; #(parameter int CNT_W = 16);
  logic id_valid;
  reg_t id_rs;
  reg_t id_rt;
  logic id_uses_rs;
  logic id_uses_rt;
  logic ex_valid;
  reg_t ex_rs;
  reg_t ex_rt;
  reg_t ex_dest;
  logic ex_reg_write;
  logic ex_mem_read;
  logic ex_flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic pc_write_en;
  logic ifid_write_en;
  logic idex_bubble;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_valid, ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_flush,
    input fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en, idex_bubble, stall_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input ex_valid, ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_flush,
    output fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en, idex_bubble, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit_stage_dest_slice.sv
// stage_dest_slice: one pipeline stage's {dest, reg_write, mem_read, valid} record
// ports: clk, rst_n (sync active-low clear), d (next record), q (registered record)
module stage_dest_slice import hazard_forward_unit_pkg::*; (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk) q <= rst_n ? d : '0;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding, ID load-use stall and saturating stall counter
// ports: clk, rst_n (sync active-low), bus (slave modport: ID/EX inputs, selects, enables, stall_count)
module hazard_forward_unit import hazard_forward_unit_pkg::*; #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  hazard_forward_unit_if.slave bus
);
  stage_t ex_s, mem_s, wb_s;
  logic mem_a, wb_a, mem_b, wb_b, stall, live;
  logic [CNT_W-1:0] cnt;
  logic unused;
  // A flushed EX instruction enters MEM as invalid so it can never be forwarded.
  assign ex_s = '{bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read, bus.ex_valid & ~bus.ex_flush};
  stage_dest_slice u_mem (.clk(clk), .rst_n(rst_n), .d(ex_s), .q(mem_s));
  stage_dest_slice u_wb (.clk(clk), .rst_n(rst_n), .d(mem_s), .q(wb_s));
  assign mem_a = hit(mem_s.valid, mem_s.reg_write, mem_s.dest, bus.ex_rs);
  assign wb_a = hit(wb_s.valid, wb_s.reg_write, wb_s.dest, bus.ex_rs);
  assign mem_b = hit(mem_s.valid, mem_s.reg_write, mem_s.dest, bus.ex_rt);
  assign wb_b = hit(wb_s.valid, wb_s.reg_write, wb_s.dest, bus.ex_rt);
  assign live = rst_n & bus.ex_valid;
  // MEM holds the newer value, so it wins over WB.
  assign bus.fwd_a_sel = !live ? FWD_RF : mem_a ? FWD_MEM : wb_a ? FWD_WB : FWD_RF;
  assign bus.fwd_b_sel = !live ? FWD_RF : mem_b ? FWD_MEM : wb_b ? FWD_WB : FWD_RF;
  assign stall = bus.id_valid & bus.ex_valid & ~bus.ex_flush & bus.ex_mem_read & bus.ex_reg_write
               & (bus.ex_dest != REG_ZERO)
               & ((bus.id_uses_rs & (bus.id_rs == bus.ex_dest)) | (bus.id_uses_rt & (bus.id_rt == bus.ex_dest)));
  assign bus.pc_write_en = ~(rst_n & stall);
  assign bus.ifid_write_en = ~(rst_n & stall);
  assign bus.idex_bubble = rst_n & stall;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (stall && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign bus.stall_count = cnt;
  // Load flags ride along for debug visibility; no hazard decision reads them past EX.
  assign unused = &{1'b0, mem_s.mem_read, wb_s.mem_read};
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed and randomized checks of hazard_forward_unit against an instruction-stream model
module tb_hazard_forward_unit;
  typedef struct {
    logic valid;
    logic [4:0] rs, rt, dest;
    logic urs, urt, wr, ld;
  } inst_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  int n_vec = 0;
  int n_bad = 0;
  int cnt_m = 0;
  bit cnt_known = 0;
  bit coherent = 0;
  inst_t id_i, ex_i, nop;
  inst_t hist [2];
  logic [1:0] got_a, got_b;
  logic got_pc, got_bub;
  int got_cnt;
  hazard_forward_unit_if #(.CNT_W(4)) bus ();
  hazard_forward_unit #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic inst_t mk(logic [4:0] rs, logic [4:0] rt, logic [4:0] dest, logic urt, logic ld);
    inst_t t;
    t.valid = 1; t.rs = rs; t.rt = rt; t.dest = dest;
    t.urs = 1; t.urt = urt; t.wr = 1; t.ld = ld;
    return t;
  endfunction

  function automatic inst_t rand_inst();
    inst_t t;
    t.valid = $urandom_range(7) != 0;
    t.rs = 5'($urandom_range(3));
    t.rt = 5'($urandom_range(3));
    t.dest = 5'($urandom_range(3));
    t.urs = 1'($urandom_range(1));
    t.urt = 1'($urandom_range(1));
    t.ld = $urandom_range(2) == 0;
    t.wr = t.ld || $urandom_range(3) != 0;
    return t;
  endfunction

  // Newest in-flight producer of src wins; r0 and dead/non-writing slots never supply a value.
  function automatic logic [1:0] ref_sel(logic [4:0] src);
    if (!rst_n || !ex_i.valid) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (hist[i].valid && hist[i].wr && hist[i].dest != 0 && hist[i].dest == src)
        return i == 0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    return rst_n && id_i.valid && ex_i.valid && !flush && ex_i.ld && ex_i.wr && ex_i.dest != 0
      && ((id_i.urs && id_i.rs == ex_i.dest) || (id_i.urt && id_i.rt == ex_i.dest));
  endfunction

  task automatic cycle();
    logic s, ml;
    bus.id_valid = id_i.valid; bus.id_rs = id_i.rs; bus.id_rt = id_i.rt;
    bus.id_uses_rs = id_i.urs; bus.id_uses_rt = id_i.urt;
    bus.ex_valid = ex_i.valid; bus.ex_rs = ex_i.rs; bus.ex_rt = ex_i.rt; bus.ex_dest = ex_i.dest;
    bus.ex_reg_write = ex_i.wr; bus.ex_mem_read = ex_i.ld; bus.ex_flush = flush;
    @(negedge clk);
    s = ref_stall();
    ml = rst_n && ex_i.valid && hist[0].valid && hist[0].wr && hist[0].ld && hist[0].dest != 0
      && ((ex_i.urs && ex_i.rs == hist[0].dest) || (ex_i.urt && ex_i.rt == hist[0].dest));
    got_a = bus.fwd_a_sel; got_b = bus.fwd_b_sel; got_pc = bus.pc_write_en;
    got_bub = bus.idex_bubble; got_cnt = int'(bus.stall_count);
    chk("fwd_a", got_a, ref_sel(ex_i.rs));
    chk("fwd_b", got_b, ref_sel(ex_i.rt));
    chk("pc_we", got_pc, !s);
    chk("ifid_we", bus.ifid_write_en, !s);
    chk("bubble", got_bub, s);
    if (cnt_known) chk("stall_cnt", got_cnt, cnt_m);
    if (coherent) chk("mem_load_use", ml, 0);
    @(posedge clk);
    if (!rst_n) begin
      hist[0] = nop; hist[1] = nop; cnt_m = 0; cnt_known = 1;
    end else begin
      hist[1] = hist[0]; hist[0] = ex_i; hist[0].valid = ex_i.valid && !flush;
      if (s) cnt_m = cnt_m < 15 ? cnt_m + 1 : 15;
    end
    if (coherent) begin
      if (s) ex_i = nop;
      else begin ex_i = id_i; id_i = rand_inst(); end
      flush = $urandom_range(7) == 0;
    end
    #1;
  endtask

  initial begin
    nop = '{valid: 0, rs: 0, rt: 0, dest: 0, urs: 0, urt: 0, wr: 0, ld: 0};
    hist[0] = nop; hist[1] = nop;
    // Reset with hazard-provoking inputs: outputs must stay at their idle values.
    rst_n = 0; ex_i = mk(1, 9, 9, 1, 1); id_i = mk(9, 9, 3, 1, 0);
    repeat (2) cycle();
    chk("rst_pc", got_pc, 1);
    chk("rst_bub", got_bub, 0);
    rst_n = 1; id_i = nop;
    ex_i = mk(1, 2, 5, 1, 0); cycle();
    ex_i = mk(5, 3, 6, 1, 0); cycle(); chk("b2b_mem", got_a, 2'b10);
    ex_i = mk(1, 5, 7, 1, 0); cycle(); chk("b2b_wb", got_b, 2'b01);
    ex_i = mk(1, 2, 7, 1, 0); cycle();
    ex_i = mk(7, 1, 0, 1, 0); cycle(); chk("dbl_hit", got_a, 2'b10);
    ex_i = mk(0, 0, 1, 1, 0); cycle(); chk("r0_a", got_a, 2'b00);
    // Load-use: one stall, bubble in EX, then WB forward to the consumer.
    ex_i = mk(1, 0, 9, 0, 1); id_i = mk(2, 9, 12, 1, 0); cycle();
    chk("lu_pc", got_pc, 0); chk("lu_bub", got_bub, 1);
    ex_i = nop; cycle(); chk("lu_release", got_pc, 1);
    ex_i = id_i; id_i = nop; cycle();
    chk("lu_fwd_b", got_b, 2'b01); chk("lu_cnt", got_cnt, 1);
    // Flushed load neither stalls nor reaches MEM.
    ex_i = mk(1, 0, 9, 0, 1); id_i = mk(9, 0, 13, 0, 0); flush = 1; cycle();
    chk("fl_pc", got_pc, 1); chk("fl_bub", got_bub, 0);
    ex_i = id_i; id_i = nop; flush = 0; cycle(); chk("fl_fwd_a", got_a, 2'b00);
    // Held stall saturates the counter, then a reset mid-stall clears everything.
    ex_i = mk(1, 0, 9, 0, 1); id_i = mk(9, 9, 14, 1, 0);
    repeat (20) cycle();
    rst_n = 0; cycle();
    chk("sat_cnt", got_cnt, 15); chk("rst_stall_pc", got_pc, 1); chk("rst_stall_bub", got_bub, 0);
    rst_n = 1; ex_i = mk(9, 9, 15, 1, 0); id_i = nop; cycle();
    chk("post_rst_cnt", got_cnt, 0); chk("post_rst_a", got_a, 0); chk("post_rst_b", got_b, 0);
    // Coherent random instruction stream: ID flows into EX unless stalled.
    ex_i = nop; id_i = rand_inst(); coherent = 1;
    repeat (800) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
